scanline_bank_buffer: RTL and testbench
=======================================

SCANLINE_BANK_BUFFER -- requirements
Module: scanline_bank_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter BUFFER_ADDR_WIDTH, default 8, word address width per bank; bank depth SHALL be 2**BUFFER_ADDR_WIDTH.
REQ-003 Parameter BANK_ADDR_WIDTH, default 1, bank index width; bank count BANKS SHALL be 2**BANK_ADDR_WIDTH (legal 1..3).
REQ-004 clk  in  1  single clock; all sequential logic SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 write_addr  in  BUFFER_ADDR_WIDTH  word address within the current fill bank.
REQ-007 write_data  in  DATA_WIDTH  write word.
REQ-008 write_strobe  in  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
REQ-009 write_enable  in  1  write request.
REQ-010 write_commit  in  1  marks the fill bank complete and hands it to the read side.
REQ-011 write_ready  out  1  a free bank is available for filling.
REQ-012 read_addr  in  BUFFER_ADDR_WIDTH  word address within the current scan bank.
REQ-013 read_enable  in  1  read request.
REQ-014 read_data  out  DATA_WIDTH  registered read word.
REQ-015 read_valid  out  1  read_data carries the result of an accepted read.
REQ-016 read_release  in  1  returns the scan bank to the free pool.
REQ-017 read_ready  out  1  a committed bank is available for scanning.
REQ-018 fill_level  out  BANK_ADDR_WIDTH+1  number of committed, unreleased banks.
REQ-019 overrun  out  1  sticky write-side protocol error.
REQ-020 underrun  out  1  sticky read-side protocol error.

Function
REQ-021 Storage SHALL be BANKS x 2**BUFFER_ADDR_WIDTH words, used as a ring; internal pointers wbank (fill) and rbank (scan) SHALL wrap modulo BANKS.
REQ-022 write_ready SHALL equal (fill_level < BANKS); read_ready SHALL equal (fill_level > 0); both combinational from registered state.
REQ-023 write_enable with write_ready SHALL update only strobed bytes of bank wbank at write_addr; unstrobed bytes unchanged.
REQ-024 write_commit with write_ready SHALL advance wbank by 1 and increment fill_level next cycle.
REQ-025 read_enable with read_ready SHALL load read_data from bank rbank at read_addr and pulse read_valid the next cycle (latency 1).
REQ-026 Without an accepted read, read_valid SHALL be 0 the next cycle and read_data SHALL hold.
REQ-027 read_release with read_ready SHALL advance rbank by 1 and decrement fill_level next cycle.
REQ-028 Accepted commit and release in the same cycle: both pointers advance, fill_level unchanged.
REQ-029 Write and commit in the same cycle: write lands in the pre-advance bank; read and release in the same cycle: read uses the pre-advance bank.
REQ-030 write_enable or write_commit while write_ready=0 SHALL be ignored and SHALL set overrun.
REQ-031 read_enable or read_release while read_ready=0 SHALL be ignored, produce no read_valid, and set underrun.
REQ-032 overrun and underrun SHALL clear only on reset.
REQ-033 The scan bank and fill bank SHALL never coincide while both sides are ready; no read-during-write hazard handling is required.

Reset
REQ-034 reset=1 SHALL immediately force wbank=0, rbank=0, fill_level=0, read_valid=0, read_data=0, overrun=0, underrun=0; write_ready=1, read_ready=0.
REQ-035 Memory contents SHALL NOT be reset; reset mid-fill or mid-scan SHALL discard all bank ownership.

Verification (defaults: 16-bit, 256 words, 2 banks)
REQ-036 Write 0x1234 to addr 5 strobe 11, commit, read addr 5 -> next cycle read_valid=1, read_data=0x1234, fill_level=1.
REQ-037 Write 0xFFFF addr 7 strobe 11, then 0xAB00 strobe 10, commit, read addr 7 -> read_data=0xABFF.
REQ-038 Commit twice (fill_level=2), write_enable and commit again -> write_ready=0, overrun=1, fill_level stays 2, bank 0 data intact.
REQ-039 With fill_level=1, commit and release in same cycle -> fill_level=1, rbank=1, wbank wraps 1->0.
REQ-040 From reset, read_enable -> read_valid=0, underrun=1; assert reset mid-scan with fill_level=2 -> fill_level=0, flags cleared, read_ready=0.

Source files
------------

// File: rtl/scanline_bank_buffer.sv
// Multi-bank scanline ring buffer: the write side fills one bank while the
// read side scans another. Banks pass from fill to scan on commit and
// return to the free pool on release.
module scanline_bank_buffer #(
  parameter int DATA_WIDTH        = 16,
  parameter int BUFFER_ADDR_WIDTH = 8,
  parameter int BANK_ADDR_WIDTH   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BUFFER_ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [DATA_WIDTH/8-1:0]      write_strobe,
  input  logic                         write_enable,
  input  logic                         write_commit,
  output logic                         write_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  input  logic                         read_enable,
  output logic [DATA_WIDTH-1:0]        read_data,
  output logic                         read_valid,
  input  logic                         read_release,
  output logic                         read_ready,
  output logic [BANK_ADDR_WIDTH:0]     fill_level,
  output logic                         overrun,
  output logic                         underrun
);

  localparam int BANKS = 2 ** BANK_ADDR_WIDTH;
  localparam int DEPTH = 2 ** BUFFER_ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [BANK_ADDR_WIDTH:0] BANKS_CNT = (BANK_ADDR_WIDTH + 1)'(BANKS);

  logic [DATA_WIDTH-1:0]      mem [BANKS*DEPTH];
  logic [BANK_ADDR_WIDTH-1:0] wbank;
  logic [BANK_ADDR_WIDTH-1:0] rbank;
  logic [BANK_ADDR_WIDTH:0]   fill_cnt;
  logic [DATA_WIDTH-1:0]      rd_data_p1;
  logic                       vld_p1;
  logic                       overrun_flag;
  logic                       underrun_flag;

  logic wr_acc;
  logic cm_acc;
  logic rd_acc;
  logic rl_acc;

  // Handshake view derived purely from the registered occupancy count.
  assign write_ready = (fill_cnt < BANKS_CNT);
  assign read_ready  = (fill_cnt != '0);

  assign wr_acc = write_enable & write_ready;
  assign cm_acc = write_commit & write_ready;
  assign rd_acc = read_enable  & read_ready;
  assign rl_acc = read_release & read_ready;

  // ---- stage p0 -> p1: memory write / registered read ----

  // Byte-masked write into the current fill bank; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (write_strobe[b]) begin
          mem[{wbank, write_addr}][b*8 +: 8] <= write_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        rd_data_p1 <= mem[{rbank, read_addr}];
      end
    end
  end

  // Bank ownership: ring pointers wrap naturally at BANKS, count tracks committed banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank    <= '0;
      rbank    <= '0;
      fill_cnt <= '0;
    end else begin
      if (cm_acc) wbank <= wbank + BANK_ADDR_WIDTH'(1);
      if (rl_acc) rbank <= rbank + BANK_ADDR_WIDTH'(1);
      case ({cm_acc, rl_acc})
        2'b10:   fill_cnt <= fill_cnt + (BANK_ADDR_WIDTH + 1)'(1);
        2'b01:   fill_cnt <= fill_cnt - (BANK_ADDR_WIDTH + 1)'(1);
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  // Sticky protocol-error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_flag  <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      if ((write_enable | write_commit) & ~write_ready) overrun_flag  <= 1'b1;
      if ((read_enable  | read_release) & ~read_ready)  underrun_flag <= 1'b1;
    end
  end

  assign read_data  = rd_data_p1;
  assign read_valid = vld_p1;
  assign fill_level = fill_cnt;
  assign overrun    = overrun_flag;
  assign underrun   = underrun_flag;

endmodule

// File: tb/tb_scanline_bank_buffer.sv
// Directed bench for scanline_bank_buffer at default parameters
// (16-bit words, 256 words per bank, 2 banks).
module tb_scanline_bank_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  write_addr;
  logic [15:0] write_data;
  logic [1:0]  write_strobe;
  logic        write_enable;
  logic        write_commit;
  logic        write_ready;
  logic [7:0]  read_addr;
  logic        read_enable;
  logic [15:0] read_data;
  logic        read_valid;
  logic        read_release;
  logic        read_ready;
  logic [1:0]  fill_level;
  logic        overrun;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  scanline_bank_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .write_enable (write_enable),
    .write_commit (write_commit),
    .write_ready  (write_ready),
    .read_addr    (read_addr),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_release (read_release),
    .read_ready   (read_ready),
    .fill_level   (fill_level),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic idle();
    write_addr   = '0;
    write_data   = '0;
    write_strobe = '0;
    write_enable = 1'b0;
    write_commit = 1'b0;
    read_addr    = '0;
    read_enable  = 1'b0;
    read_release = 1'b0;
  endtask

  // Apply current inputs for one rising edge, then return them to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    #2;
    reset = 1'b1;
    #3;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s, input logic c);
    write_addr = a; write_data = d; write_strobe = s; write_enable = 1'b1; write_commit = c;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL reset_write_ready got %b want 1", write_ready); end
    tests++; if (read_ready !== 1'b0) begin fails++; $display("FAIL reset_read_ready got %b want 0", read_ready); end
    tests++; if (fill_level !== 2'd0) begin fails++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    tests++; if (read_valid !== 1'b0) begin fails++; $display("FAIL reset_read_valid got %b want 0", read_valid); end
    tests++; if (read_data !== 16'h0000) begin fails++; $display("FAIL reset_read_data got %h want 0000", read_data); end
    tests++; if ({overrun, underrun} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {overrun, underrun}); end
  endtask

  task automatic test_basic();
    wr(8'd5, 16'h1234, 2'b11, 1'b0);
    write_commit = 1'b1; tick();
    tests++; if (fill_level !== 2'd1) begin fails++; $display("FAIL basic_fill_after_commit got %0d want 1", fill_level); end
    tests++; if (read_ready !== 1'b1) begin fails++; $display("FAIL basic_read_ready got %b want 1", read_ready); end
    read_addr = 8'd5; read_enable = 1'b1; tick();
    tests++; if (read_valid !== 1'b1) begin fails++; $display("FAIL basic_read_valid got %b want 1", read_valid); end
    tests++; if (read_data !== 16'h1234) begin fails++; $display("FAIL basic_read_data got %h want 1234", read_data); end
    tests++; if (fill_level !== 2'd1) begin fails++; $display("FAIL basic_fill_after_read got %0d want 1", fill_level); end
    tick();
    tests++; if (read_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %b want 0", read_valid); end
    tests++; if (read_data !== 16'h1234) begin fails++; $display("FAIL basic_data_hold got %h want 1234", read_data); end
    read_release = 1'b1; tick();
    tests++; if (fill_level !== 2'd0) begin fails++; $display("FAIL basic_fill_after_release got %0d want 0", fill_level); end
  endtask

  // Runs in bank 1 (pointers left at 1 by test_basic).
  task automatic test_strobe();
    wr(8'd7, 16'hFFFF, 2'b11, 1'b0);
    wr(8'd7, 16'hAB00, 2'b10, 1'b0);
    wr(8'd8, 16'h1111, 2'b11, 1'b0);
    wr(8'd8, 16'h2222, 2'b01, 1'b1);
    read_addr = 8'd7; read_enable = 1'b1; tick();
    tests++; if (read_data !== 16'hABFF) begin fails++; $display("FAIL strobe_high got %h want abff", read_data); end
    read_addr = 8'd8; read_enable = 1'b1; read_release = 1'b1; tick();
    tests++; if (read_data !== 16'h1122) begin fails++; $display("FAIL strobe_low got %h want 1122", read_data); end
    tests++; if (fill_level !== 2'd0) begin fails++; $display("FAIL strobe_fill got %0d want 0", fill_level); end
  endtask

  task automatic test_overrun();
    do_reset();
    wr(8'd3, 16'hBEEF, 2'b11, 1'b1);
    wr(8'd3, 16'hCAFE, 2'b11, 1'b1);
    tests++; if (fill_level !== 2'd2) begin fails++; $display("FAIL ovr_fill_full got %0d want 2", fill_level); end
    tests++; if (write_ready !== 1'b0) begin fails++; $display("FAIL ovr_write_ready got %b want 0", write_ready); end
    wr(8'd3, 16'h0000, 2'b11, 1'b1);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
    tests++; if (fill_level !== 2'd2) begin fails++; $display("FAIL ovr_fill_hold got %0d want 2", fill_level); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ovr_underrun got %b want 0", underrun); end
    read_addr = 8'd3; read_enable = 1'b1; read_release = 1'b1; tick();
    tests++; if (read_data !== 16'hBEEF) begin fails++; $display("FAIL ovr_bank0_intact got %h want beef", read_data); end
    read_addr = 8'd3; read_enable = 1'b1; tick();
    tests++; if (read_data !== 16'hCAFE) begin fails++; $display("FAIL ovr_bank1 got %h want cafe", read_data); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_commit_release();
    do_reset();
    wr(8'd10, 16'h0A0A, 2'b11, 1'b1);
    write_addr = 8'd10; write_data = 16'h1B1B; write_strobe = 2'b11;
    write_enable = 1'b1; write_commit = 1'b1; read_release = 1'b1; tick();
    tests++; if (fill_level !== 2'd1) begin fails++; $display("FAIL cr_fill got %0d want 1", fill_level); end
    wr(8'd10, 16'h2C2C, 2'b11, 1'b1);
    tests++; if (fill_level !== 2'd2) begin fails++; $display("FAIL cr_fill_wrap got %0d want 2", fill_level); end
    read_addr = 8'd10; read_enable = 1'b1; read_release = 1'b1; tick();
    tests++; if (read_data !== 16'h1B1B) begin fails++; $display("FAIL cr_rbank1 got %h want 1b1b", read_data); end
    tests++; if (fill_level !== 2'd1) begin fails++; $display("FAIL cr_fill_release got %0d want 1", fill_level); end
    read_addr = 8'd10; read_enable = 1'b1; tick();
    tests++; if (read_data !== 16'h2C2C) begin fails++; $display("FAIL cr_wbank_wrapped got %h want 2c2c", read_data); end
  endtask

  task automatic test_underrun_reset();
    do_reset();
    read_addr = 8'd1; read_enable = 1'b1; tick();
    tests++; if (read_valid !== 1'b0) begin fails++; $display("FAIL udr_valid got %b want 0", read_valid); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL udr_flag got %b want 1", underrun); end
    read_release = 1'b1; tick();
    tests++; if (fill_level !== 2'd0) begin fails++; $display("FAIL udr_release_ignored got %0d want 0", fill_level); end
    write_commit = 1'b1; tick();
    write_commit = 1'b1; tick();
    read_enable = 1'b1; tick();
    tests++; if (fill_level !== 2'd2 || read_valid !== 1'b1) begin fails++; $display("FAIL udr_prefill got fill=%0d valid=%b want fill=2 valid=1", fill_level, read_valid); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (fill_level !== 2'd0) begin fails++; $display("FAIL async_reset_fill got %0d want 0", fill_level); end
    tests++; if ({overrun, underrun, read_valid} !== 3'b000) begin fails++; $display("FAIL async_reset_flags got %b want 000", {overrun, underrun, read_valid}); end
    tests++; if ({write_ready, read_ready} !== 2'b10) begin fails++; $display("FAIL async_reset_ready got %b want 10", {write_ready, read_ready}); end
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_strobe();
    test_overrun();
    test_commit_release();
    test_underrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
